timed_countdown_display: RTL
============================

// Module: timed_countdown_display
// PURPOSE
// - Parametrised successor of the single-button timed FSM top: debounced start/pause and clear
//   buttons drive a MM:SS countdown FSM.
// - Result is shown on a multiplexed N_DIGITS seven-segment display.
// - Debounce, timed FSM, tick generation and display scan are in one block with one clock domain.
// - Sits directly under the board top; buttons in, segment/anode pins out.
// PARAMETERS
// - N_DIGITS      8         number of display digits, 4..8; digits 0-3 = MM:SS, upper digits blank
// - DEBOUNCE_CYC  1000000   consecutive stable cycles needed to accept a button level change
// - TICK_DIV      100000000 clk cycles per countdown second
// - SCAN_DIV      50000     clk cycles each digit stays enabled during scan
// - PRESET_MIN    1         reload minutes, 0..99
// - PRESET_SEC    30        reload seconds, 0..59
// PORTS
// - clk          in   1         system clock, all logic on rising edge
// - reset        in   1         synchronous, active-low reset
// - btn_start    in   1         raw start/pause button, active-high, asynchronous to clk
// - btn_clear    in   1         raw clear button, active-high, asynchronous to clk
// - segments     out  7         segments g..a, active-low
// - anodes       out  N_DIGITS  digit enables, active-low, one-hot-low while scanning
// - state        out  2         FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
// - done         out  1         high while state==DONE
// BEHAVIOUR
// - Clocking and reset: single clk domain. reset sampled on the clock edge: low -> every register
//   cleared on that edge.
// - Reset values: anodes all 1, segments 7'h7F, state IDLE, done 0, count = PRESET in BCD,
//   tick/scan/debounce counters 0.
// - Debounce, per button:
//   - 2-FF synchronizer, then counter. Counter runs while the synced value differs from the
//     accepted level; it clears when they match.
//   - Accepted level flips when the counter reaches DEBOUNCE_CYC-1.
//   - One-cycle press pulse on an accepted 0->1 flip. No pulse on release.
// - FSM transitions on press pulses:
//   - IDLE --start--> RUN, only if count != 00:00; tick counter cleared.
//   - RUN --start--> PAUSE. Tick counter is held, not cleared.
//   - PAUSE --start--> RUN. Tick counter resumes from the held value.
//   - DONE --start--> IDLE, count reloaded.
//   - clear from any state -> IDLE, count reloaded. clear beats start when both pulse in the same cycle.
// - Tick: counter runs 0..TICK_DIV-1 only in RUN and wraps. The tick occurs on the cycle it wraps.
// - Countdown on each tick, BCD decrement with borrow:
//   - sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; minutes decrement the same way.
// - Terminal count: if the tick produces 00:00, the next state is DONE in the same cycle.
//   - done goes high one cycle after that tick. count holds at 00:00.
// - PRESET 00:00: start in IDLE is ignored; state stays IDLE.
// - Scan:
//   - Digit index increments every SCAN_DIV cycles and wraps N_DIGITS-1 -> 0.
//   - anodes[i] low only for the current index. segments are registered with the anode, so both
//     change on the same edge.
//   - Digit map: 0 sec_ones, 1 sec_tens, 2 min_ones, 3 min_tens.
//   - Digits >= 4 are blank: segments 7'h7F, anode still scanned.
//   - Decoder covers 0-9; any other code shows blank.
// - Reset mid-countdown: count returns to PRESET and state returns to IDLE on that edge.
// CONFIGURATION
// - BLINK_EN defined:
//   - In DONE, a free-running half-period counter toggles every TICK_DIV/2 cycles.
//   - While blink is low, all anodes are forced to 1.
//   - Blink phase is cleared on entry to DONE, so the display is visible for the first half-second.
// - BLINK_EN undefined: DONE shows a steady 00:00. No blink logic is synthesised.
// TESTING (DEBOUNCE_CYC=4, TICK_DIV=10, SCAN_DIV=2, N_DIGITS=8, PRESET 0:03)
// - Reset low 2 cycles, then high -> state 0, done 0, anodes 8'hFF on first cycle.
//   Scan then starts with anodes 8'hFE.
// - btn_start 3-cycle glitch -> no state change.
//   Held 10 cycles -> state 1, entered 6 cycles after the rising edge (2 sync + 4 debounce).
// - RUN for 30 cycles -> count 00:03 -> 00:02 -> 00:01 -> 00:00, state 3, done 1.
//   digit0 segments = 7'h40 ("0").
// - Start pulse at 00:02 + 5 tick cycles -> PAUSE. Second start -> RUN.
//   Next decrement 5 cycles later, not 10.
// - btn_start and btn_clear accepted in the same cycle during RUN -> state 0, count 00:03.
// - Count 10:00 via PRESET_MIN=10, PRESET_SEC=0 -> one tick gives 09:59 (borrow chain).
//   With BLINK_EN, DONE anodes alternate 8'hFF every 5 cycles.

Source files
------------

// File: rtl/timed_countdown_display.sv
// MM:SS countdown timer with debounced start/pause and clear buttons, shown on a scanned 7-seg display.
// Optional BLINK_EN macro: blink the whole display at half-second rate while in DONE.
module timed_countdown_display #(
    parameter int N_DIGITS     = 8,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int TICK_DIV     = 100000000,
    parameter int SCAN_DIV     = 50000,
    parameter int PRESET_MIN   = 1,
    parameter int PRESET_SEC   = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_start,
    input  logic                btn_clear,
    output logic [6:0]          segments,
    output logic [N_DIGITS-1:0] anodes,
    output logic [1:0]          state,
    output logic                done
);
    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = $clog2(N_DIGITS);

    localparam logic [3:0] P_MT = 4'(PRESET_MIN / 10);
    localparam logic [3:0] P_MO = 4'(PRESET_MIN % 10);
    localparam logic [3:0] P_ST = 4'(PRESET_SEC / 10);
    localparam logic [3:0] P_SO = 4'(PRESET_SEC % 10);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    state_t state_q, state_d;

    // Debounce: bit 0 = start, bit 1 = clear
    logic [1:0]       raw, sync1, sync2, level, press;
    logic [DEB_W-1:0] deb_cnt [2];

    assign raw = {btn_clear, btn_start};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < 2; i++)
            press[i] = sync2[i] && !level[i] && (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC - 1));
    end

    // Countdown registers and BCD decrement with borrow
    logic [3:0] sec_o, sec_t, min_o, min_t;
    logic [3:0] dec_so, dec_st, dec_mo, dec_mt;
    logic       b1, b2, b3, dec_zero, count_zero;

    always_comb begin
        b1       = (sec_o == 4'd0);
        b2       = b1 && (sec_t == 4'd0);
        b3       = b2 && (min_o == 4'd0);
        dec_so   = b1 ? 4'd9 : sec_o - 4'd1;
        dec_st   = b1 ? ((sec_t == 4'd0) ? 4'd5 : sec_t - 4'd1) : sec_t;
        dec_mo   = b2 ? ((min_o == 4'd0) ? 4'd9 : min_o - 4'd1) : min_o;
        dec_mt   = b3 ? ((min_t == 4'd0) ? 4'd9 : min_t - 4'd1) : min_t;
        dec_zero = (dec_so == 4'd0) && (dec_st == 4'd0) && (dec_mo == 4'd0) && (dec_mt == 4'd0);
        count_zero = (sec_o == 4'd0) && (sec_t == 4'd0) && (min_o == 4'd0) && (min_t == 4'd0);
    end

    logic [TICK_W-1:0] tick_cnt;
    logic              tick, reload, do_dec;

    assign tick = (state_q == RUN) && (tick_cnt == TICK_W'(TICK_DIV - 1));

    // A tick is never lost: it still decrements when start or terminal count coincides
    always_comb begin
        state_d = state_q;
        reload  = 1'b0;
        do_dec  = 1'b0;
        if (press[1]) begin
            state_d = IDLE;
            reload  = 1'b1;
        end else begin
            case (state_q)
                IDLE:  if (press[0] && !count_zero) state_d = RUN;
                RUN: begin
                    if (tick) begin
                        do_dec = 1'b1;
                        if (dec_zero)      state_d = DONE;
                        else if (press[0]) state_d = PAUSE;
                    end else if (press[0]) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: if (press[0]) state_d = RUN;
                DONE: begin
                    if (press[0]) begin
                        state_d = IDLE;
                        reload  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            tick_cnt <= '0;
            {min_t, min_o, sec_t, sec_o} <= {P_MT, P_MO, P_ST, P_SO};
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == RUN) tick_cnt <= '0;
            else if (state_q == RUN)               tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (reload)      {min_t, min_o, sec_t, sec_o} <= {P_MT, P_MO, P_ST, P_SO};
            else if (do_dec) {min_t, min_o, sec_t, sec_o} <= {dec_mt, dec_mo, dec_st, dec_so};
        end
    end

    assign state = state_q;
    assign done  = (state_q == DONE);

    // Display scan
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic [3:0]        digit_val;
    logic              blank_all;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_W'(N_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        digit_val = 4'hF;
        case (int'(digit_idx))
            0:       digit_val = sec_o;
            1:       digit_val = sec_t;
            2:       digit_val = min_o;
            3:       digit_val = min_t;
            default: digit_val = 4'hF;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

`ifdef BLINK_EN
    localparam int HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
    logic [TICK_W-1:0] blink_cnt;
    logic              blink_hide;

    // Phase restarts visible every time DONE is entered
    always_ff @(posedge clk) begin
        if (!reset || state_q != DONE) begin
            blink_cnt  <= '0;
            blink_hide <= 1'b0;
        end else if (blink_cnt == TICK_W'(HALF - 1)) begin
            blink_cnt  <= '0;
            blink_hide <= ~blink_hide;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank_all = blink_hide;
`else
    assign blank_all = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            anodes   <= '1;
            segments <= 7'h7F;
        end else begin
            anodes   <= blank_all ? '1 : ~({{(N_DIGITS-1){1'b0}}, 1'b1} << digit_idx);
            segments <= seg7(digit_val);
        end
    end
endmodule
